bcd_stopwatch_lap: RTL and testbench

//  Parametrised BCD stopwatch: time-of-day style cascade (centiseconds, seconds, minutes, hours)

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/sw_btn_sync.sv | 31 +++
 rtl/bcd_stopwatch_lap.sv | 194 +++++++++++++++++++
 tb/tb_bcd_stopwatch_lap.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch.
// Holds the run-state encoding, the BCD nibble width and the per-digit
// rollover value (9 for decimal digits, 5 for the tens of seconds/minutes).
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Highest legal value of digit idx: d3 and d5 are the tens of seconds
  // and tens of minutes, every other digit is plain decimal.
  function automatic logic [BCD_W-1:0] digit_max(input int idx);
    if (idx == 3 || idx == 5) begin
      return 4'd5;
    end
    return 4'd9;
  endfunction

endpackage

// File: rtl/sw_btn_sync.sv
// Button synchroniser: two flops bring the asynchronous level into clk,
// a third flop remembers the previous synchronised level so a rising edge
// turns into a single-cycle pulse. A level first seen at edge E0 produces a
// pulse that the consumer acts on at edge E2.
module sw_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  // Shift the raw level through the synchroniser / history chain.
  always_comb begin
    sync_d = {sync_q[1:0], btn_i};
  end

  // Synchroniser flops, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bcd_stopwatch_lap.sv
// BCD stopwatch with prescaler, run/pause/clear control, leading-zero
// blanking and sticky overflow. Digits are centiseconds (d0,d1), seconds
// (d2,d3), minutes (d4,d5) and hours (d6..).
// Optional lap/freeze display is built when STOPWATCH_LAP_EN is defined;
// otherwise btn_lap is ignored and lap_active is tied low.
module bcd_stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int NDIG       = 8,
  parameter int MIN_DIGITS = 3,
  parameter int WRAP       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    btn_startstop,
  input  logic                    btn_clear,
  input  logic                    btn_lap,
  output logic [BCD_W*NDIG-1:0]   bcd,
  output logic [NDIG-1:0]         digit_en,
  output logic                    running,
  output logic                    lap_active,
  output logic                    overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW  = BCD_W * NDIG;

  logic ss_pulse;
  logic clr_pulse;

  sw_btn_sync u_sync_ss (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_startstop),
    .pulse_o (ss_pulse)
  );

  sw_btn_sync u_sync_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_clear),
    .pulse_o (clr_pulse)
  );

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            tick;
  logic [NDIG-1:0] at_max;
  logic [NDIG-1:0] lower_max;
  logic            all_max;
  logic [CW-1:0]   count_inc;

  assign tick = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));

  // Digit cascade: each digit steps only when every lower digit is at its
  // rollover value, so all digits update together on the tick edge.
  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      localparam logic [NDIG-1:0] LMASK = NDIG'((64'd1 << gi) - 64'd1);
      logic [BCD_W-1:0] dig;
      assign dig           = count_q[BCD_W*gi +: BCD_W];
      assign at_max[gi]    = (dig == digit_max(gi));
      assign lower_max[gi] = &(at_max | ~LMASK);
      assign count_inc[BCD_W*gi +: BCD_W] =
          !lower_max[gi] ? dig :
          at_max[gi]     ? '0  : dig + 4'd1;
    end
  endgenerate

  assign all_max = &at_max;

  // Control: clear dominates, then the count/prescaler step, then start/stop.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clr_pulse) begin
      state_d    = ST_IDLE;
      presc_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (tick) begin
        presc_d = '0;
        if (all_max) begin
          overflow_d = 1'b1;
          if (WRAP != 0) begin
            count_d = count_inc;
          end else begin
            // Saturate: hold the all-max display and stop counting.
            state_d = ST_PAUSE;
          end
        end else begin
          count_d = count_inc;
        end
      end else if (state_q == ST_RUN) begin
        presc_d = presc_q + PW'(1);
      end
      if (ss_pulse) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: begin
            // A saturated count may only leave PAUSE through clear.
            if (!(overflow_q && (WRAP == 0))) begin
              state_d = ST_RUN;
            end
          end
          default:  state_d = ST_IDLE;
        endcase
      end
    end
  end

  // State, prescaler, count and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign running  = (state_q == ST_RUN);
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic          lap_pulse;
  logic          lap_active_q, lap_active_d;
  logic [CW-1:0] lap_reg_q, lap_reg_d;

  sw_btn_sync u_sync_lap (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_lap),
    .pulse_o (lap_pulse)
  );

  // Lap toggles the frozen display; it loses to clear and start/stop.
  always_comb begin
    lap_active_d = lap_active_q;
    lap_reg_d    = lap_reg_q;
    if (clr_pulse) begin
      lap_active_d = 1'b0;
    end else if (lap_pulse && !ss_pulse && (state_q != ST_IDLE)) begin
      lap_active_d = !lap_active_q;
      if (!lap_active_q) begin
        lap_reg_d = count_q;
      end
    end
  end

  // Lap flag and captured value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_active_q <= 1'b0;
      lap_reg_q    <= '0;
    end else begin
      lap_active_q <= lap_active_d;
      lap_reg_q    <= lap_reg_d;
    end
  end

  assign lap_active = lap_active_q;
  assign bcd        = lap_active_q ? lap_reg_q : count_q;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_active = 1'b0;
  assign bcd        = count_q;
`endif

  // Leading-zero blanking from the displayed value.
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_blank
      assign digit_en[gi] = (gi < MIN_DIGITS) || (|bcd[CW-1:BCD_W*gi]);
    end
  endgenerate

endmodule

// File: tb/tb_bcd_stopwatch_lap.sv
// Directed bench for bcd_stopwatch_lap with CLK_HZ=400, TICK_HZ=100 (DIV=4).
// A vector table covers start/pause/resume/clear timing; hand sequences
// cover reset mid-run, minute cascade, clear+start priority, lap freeze and
// overflow on 6-digit instances with WRAP=0 and WRAP=1.
module tb_bcd_stopwatch_lap;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        btn_ss, btn_clr, btn_lap;
  logic [31:0] bcd;
  logic [7:0]  digit_en;
  logic        running, lap_active, overflow;

  logic        b6_ss, b6_clr, b6_lap;
  logic [23:0] bcd_w0, bcd_w1;
  logic [5:0]  en_w0, en_w1;
  logic        run_w0, run_w1, lap_w0, lap_w1, ovf_w0, ovf_w1;

  int tests;
  int fails;

  bcd_stopwatch_lap #(.CLK_HZ(400), .TICK_HZ(100), .NDIG(8), .MIN_DIGITS(3), .WRAP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_startstop(btn_ss), .btn_clear(btn_clr), .btn_lap(btn_lap),
    .bcd(bcd), .digit_en(digit_en), .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  bcd_stopwatch_lap #(.CLK_HZ(400), .TICK_HZ(100), .NDIG(6), .MIN_DIGITS(3), .WRAP(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .btn_startstop(b6_ss), .btn_clear(b6_clr), .btn_lap(b6_lap),
    .bcd(bcd_w0), .digit_en(en_w0), .running(run_w0), .lap_active(lap_w0), .overflow(ovf_w0)
  );

  bcd_stopwatch_lap #(.CLK_HZ(400), .TICK_HZ(100), .NDIG(6), .MIN_DIGITS(3), .WRAP(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .btn_startstop(b6_ss), .btn_clear(b6_clr), .btn_lap(b6_lap),
    .bcd(bcd_w1), .digit_en(en_w1), .running(run_w1), .lap_active(lap_w1), .overflow(ovf_w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  typedef struct {
    string       name;
    logic        ss;
    logic        clr;
    int          cyc;
    logic        exp_run;
    logic [31:0] exp_bcd;
  } vec_t;

  vec_t vecs [18];

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    b6_ss = 1'b0; b6_clr = 1'b0; b6_lap = 1'b0;

    // name, start, clear, cycles to wait, expected running, expected bcd
    vecs[0]  = '{"idle",          1'b0, 1'b0,  1, 1'b0, 32'h0};
    vecs[1]  = '{"sync_latency",  1'b1, 1'b0,  2, 1'b0, 32'h0};
    vecs[2]  = '{"start_at_e2",   1'b1, 1'b0,  1, 1'b1, 32'h0};
    vecs[3]  = '{"four_ticks",    1'b0, 1'b0, 16, 1'b1, 32'h4};
    vecs[4]  = '{"pause",         1'b1, 1'b0,  3, 1'b0, 32'h4};
    vecs[5]  = '{"pause_frozen",  1'b0, 1'b0, 40, 1'b0, 32'h4};
    vecs[6]  = '{"resume",        1'b1, 1'b0,  3, 1'b1, 32'h4};
    vecs[7]  = '{"phase_kept",    1'b0, 1'b0,  1, 1'b1, 32'h5};
    vecs[8]  = '{"before_tick",   1'b0, 1'b0,  3, 1'b1, 32'h5};
    vecs[9]  = '{"next_tick",     1'b0, 1'b0,  1, 1'b1, 32'h6};
    vecs[10] = '{"clear_run",     1'b0, 1'b1,  3, 1'b0, 32'h0};
    vecs[11] = '{"idle_no_count", 1'b0, 1'b0,  8, 1'b0, 32'h0};
    vecs[12] = '{"restart",       1'b1, 1'b0,  3, 1'b1, 32'h0};
    vecs[13] = '{"held_one_pulse",1'b1, 1'b0,  8, 1'b1, 32'h2};
    vecs[14] = '{"release",       1'b0, 1'b0,  2, 1'b1, 32'h2};
    vecs[15] = '{"pause2",        1'b1, 1'b0,  3, 1'b0, 32'h3};
    vecs[16] = '{"clear_pause",   1'b0, 1'b1,  3, 1'b0, 32'h0};
    vecs[17] = '{"idle_after",    1'b0, 1'b0,  2, 1'b0, 32'h0};

    // Reset state.
    #1;
    check("rst_bcd", bcd, 32'h0);
    check("rst_en", {24'h0, digit_en}, 32'h07);
    check("rst_running", {31'h0, running}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_lap", {31'h0, lap_active}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      btn_ss  = vecs[i].ss;
      btn_clr = vecs[i].clr;
      repeat (vecs[i].cyc) @(posedge clk);
      #1;
      check({vecs[i].name, "_run"}, {31'h0, running}, {31'h0, vecs[i].exp_run});
      check({vecs[i].name, "_bcd"}, bcd, vecs[i].exp_bcd);
      check({vecs[i].name, "_en"}, {24'h0, digit_en}, 32'h07);
      check({vecs[i].name, "_ovf"}, {31'h0, overflow}, 32'h0);
    end

    // Reset while counting: outputs return to reset values immediately.
    @(negedge clk); btn_ss = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); btn_ss = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("prerst_running", {31'h0, running}, 32'h1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_bcd", bcd, 32'h0);
    check("midrst_en", {24'h0, digit_en}, 32'h07);
    check("midrst_running", {31'h0, running}, 32'h0);
    check("midrst_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Cascade 00:59:99 -> 01:00:00. Tick n lands on edge E(2+4n).
    @(negedge clk); btn_ss = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); btn_ss = 1'b0;
    repeat (4 * 5999) @(posedge clk);
    #1;
    check("casc_5999_bcd", bcd, 32'h00005999);
    check("casc_5999_en", {24'h0, digit_en}, 32'h0F);
    repeat (4) @(posedge clk);
    #1;
    check("casc_min_bcd", bcd, 32'h00010000);
    check("casc_min_en", {24'h0, digit_en}, 32'h1F);
    check("casc_running", {31'h0, running}, 32'h1);

    // Clear and start together in RUN: clear wins.
    @(negedge clk); btn_ss = 1'b1; btn_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("clrss_bcd", bcd, 32'h0);
    check("clrss_running", {31'h0, running}, 32'h0);
    check("clrss_overflow", {31'h0, overflow}, 32'h0);
    check("clrss_en", {24'h0, digit_en}, 32'h07);
    @(negedge clk); btn_ss = 1'b0; btn_clr = 1'b0;
    repeat (4) @(posedge clk);

    // Lap at 00:12:34: frozen display while count runs underneath.
    @(negedge clk); btn_ss = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); btn_ss = 1'b0;
    repeat (4935) @(posedge clk);
    @(negedge clk); btn_lap = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lap_enter_active", {31'h0, lap_active}, {31'h0, LAP_ON});
    check("lap_enter_bcd", bcd, 32'h00001234);
    @(negedge clk); btn_lap = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("lap_hold_bcd", bcd, LAP_ON ? 32'h00001234 : 32'h00001239);
    check("lap_hold_running", {31'h0, running}, 32'h1);
    @(negedge clk); btn_lap = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("lap_exit_active", {31'h0, lap_active}, 32'h0);
    check("lap_exit_bcd", bcd, 32'h00001240);
    @(negedge clk); btn_lap = 1'b0; btn_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); btn_clr = 1'b0;

    // Overflow on 6-digit instances, preloaded to 59:59:99 while idle.
    @(negedge clk);
    force u_w0.count_q = 24'h595999;
    force u_w1.count_q = 24'h595999;
    #1;
    release u_w0.count_q;
    release u_w1.count_q;
    #1;
    check("pre_w0_bcd", {8'h0, bcd_w0}, 32'h595999);
    check("pre_w0_en", {26'h0, en_w0}, 32'h3F);
    @(negedge clk); b6_ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovf_w0_start", {31'h0, run_w0}, 32'h1);
    check("ovf_w1_start", {31'h0, run_w1}, 32'h1);
    @(negedge clk); b6_ss = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ovf_w0_pre", {31'h0, ovf_w0}, 32'h0);
    check("ovf_w1_prebcd", {8'h0, bcd_w1}, 32'h595999);
    repeat (1) @(posedge clk);
    #1;
    check("ovf_w0_bcd", {8'h0, bcd_w0}, 32'h595999);
    check("ovf_w0_running", {31'h0, run_w0}, 32'h0);
    check("ovf_w0_flag", {31'h0, ovf_w0}, 32'h1);
    check("ovf_w1_bcd", {8'h0, bcd_w1}, 32'h0);
    check("ovf_w1_running", {31'h0, run_w1}, 32'h1);
    check("ovf_w1_flag", {31'h0, ovf_w1}, 32'h1);
    check("ovf_w1_en", {26'h0, en_w1}, 32'h07);
    check("ovf_w1_lap", {31'h0, lap_w1}, 32'h0);
    @(negedge clk); b6_ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovf_w0_start_ignored", {31'h0, run_w0}, 32'h0);
    check("ovf_w0_still_held", {8'h0, bcd_w0}, 32'h595999);
    check("ovf_w0_lap", {31'h0, lap_w0}, 32'h0);
    @(negedge clk); b6_ss = 1'b0; b6_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ovf_w0_clr_flag", {31'h0, ovf_w0}, 32'h0);
    check("ovf_w0_clr_bcd", {8'h0, bcd_w0}, 32'h0);
    check("ovf_w1_clr_flag", {31'h0, ovf_w1}, 32'h0);
    @(negedge clk); b6_clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
